uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg_if.sv | 26 ++
 rtl/uart_tx_cfg.sv | 144 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_cfg_if.sv
// Request/handshake bundle for the configurable UART transmitter.
// Frame data and format go in; ready/busy/done come back.
interface uart_tx_cfg_if #(
  parameter int DBIT_MAX = 8
);
  logic                tx_start;
  logic [DBIT_MAX-1:0] din;
  logic [1:0]          data_bits;
  logic [1:0]          parity_mode;
  logic [1:0]          stop_mode;
  logic                tx_ready;
  logic                tx_busy;
  logic                tx_done_tick;

  modport master (
    output tx_start, din,
    output data_bits, parity_mode, stop_mode,
    input  tx_ready, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din,
    input  data_bits, parity_mode, stop_mode,
    output tx_ready, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data length, parity and stop length.
// Format and payload are captured at accept and held for the whole frame.
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s_tick,
  output logic tx,
  uart_tx_cfg_if.slave bus
);
  localparam int TW = $clog2(2 * OS);
  localparam int BW = $clog2(DBIT_MAX);
  localparam logic [TW-1:0] T_1  = TW'(OS - 1);
  localparam logic [TW-1:0] T_15 = TW'(3 * OS / 2 - 1);
  localparam logic [TW-1:0] T_2  = TW'(2 * OS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t state, state_n;

  logic [TW-1:0]       tick;
  logic [BW-1:0]       nbit;
  logic [DBIT_MAX-1:0] sreg;
  logic [DBIT_MAX-1:0] dmask;
  logic [1:0]          db_r;
  logic [1:0]          stop_r;
  logic                pen_r;
  logic                pbit_r;
  logic                pbit_in;
  logic                done_q;
  logic                tx_n;
  logic                done_n;
  logic                ready;
  logic                accept;
  logic                tick_end;
  logic                last_bit;
  logic [TW-1:0]       stop_last;

  assign accept   = bus.tx_start && ready;
  assign last_bit = nbit == (BW'(4) + BW'(db_r));

  always_comb begin
    stop_last = T_2;
    unique case (1'b1)
      (stop_r == 2'b00): stop_last = T_1;
      (stop_r == 2'b01): stop_last = T_15;
      default:           stop_last = T_2;
    endcase
  end

  assign tick_end = (state == STOP) ? (tick == stop_last)
                                    : (tick == T_1);

  // parity over only the bits that will actually be sent
  always_comb begin
    dmask = '0;
    for (int i = 0; i < DBIT_MAX; i++)
      dmask[i] = i < 5 + int'(bus.data_bits);
    pbit_in = (^(bus.din & dmask))
            ^ (bus.parity_mode == 2'b10);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (accept) state_n = START;
      START:  if (s_tick && tick_end) state_n = DATA;
      DATA:
        if (s_tick && tick_end && last_bit)
          state_n = pen_r ? PARITY : STOP;
      PARITY: if (s_tick && tick_end) state_n = STOP;
      STOP:   if (s_tick && tick_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // next line value is decided on the tick that ends the current bit
  always_comb begin
    ready  = state == IDLE;
    tx_n   = tx;
    done_n = 1'b0;
    case (state)
      IDLE:   tx_n = !accept;
      START:  if (s_tick && tick_end) tx_n = sreg[0];
      DATA:
        if (s_tick && tick_end)
          tx_n = last_bit ? (pen_r ? pbit_r : 1'b1)
                          : sreg[1];
      PARITY: if (s_tick && tick_end) tx_n = 1'b1;
      STOP:
        if (s_tick && tick_end) begin
          tx_n   = 1'b1;
          done_n = 1'b1;
        end
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx     <= 1'b1;
      done_q <= 1'b0;
      tick   <= '0;
      nbit   <= '0;
      sreg   <= '0;
      db_r   <= '0;
      stop_r <= '0;
      pen_r  <= 1'b0;
      pbit_r <= 1'b0;
    end else begin
      tx     <= tx_n;
      done_q <= done_n;
      if (accept) begin
        sreg   <= bus.din;
        db_r   <= bus.data_bits;
        stop_r <= bus.stop_mode;
        pen_r  <= bus.parity_mode == 2'b01
               || bus.parity_mode == 2'b10;
        pbit_r <= pbit_in;
        tick   <= '0;
        nbit   <= '0;
      end else if (!ready && s_tick) begin
        tick <= tick_end ? '0 : tick + 1'b1;
        if (state == DATA && tick_end) begin
          nbit <= nbit + 1'b1;
          sreg <= sreg >> 1;
        end
      end
    end
  end

  assign bus.tx_ready     = ready;
  assign bus.tx_busy      = !ready;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: each accepted frame is expanded into a per-tick line
// waveform and compared against what the line did between accept and done.
module tb_uart_tx_cfg;
  localparam int DBM = 8;
  localparam int OS  = 16;
  localparam int LIM = 3000;

  typedef struct {
    logic [255:0] w;
    int           len;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  logic s_tick;
  logic tx;

  uart_tx_cfg_if #(.DBIT_MAX(DBM)) bus ();

  uart_tx_cfg #(
    .DBIT_MAX(DBM),
    .OS      (OS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_tick(s_tick),
    .tx    (tx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  frame_t       sb[$];
  int           n_cmp  = 0;
  int           n_err  = 0;
  int           n_acc  = 0;
  int           n_done = 0;
  int           act_len = 0;
  logic [255:0] act = '0;
  bit           acc_in_done = 0;

  function automatic frame_t model(
    input logic [DBM-1:0] d,
    input logic [1:0] db,
    input logic [1:0] pm,
    input logic [1:0] sm
  );
    frame_t f;
    bit     bits[$];
    int     n;
    int     p;
    int     ns;
    bit     par;
    f.w = '0;
    n   = 5 + int'(db);
    par = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      par ^= d[i];
    end
    if (pm == 2'd1) bits.push_back(par);
    if (pm == 2'd2) bits.push_back(!par);
    p = 0;
    foreach (bits[k])
      for (int j = 0; j < OS; j++) begin
        f.w[p] = bits[k];
        p++;
      end
    ns = (sm == 2'd0) ? OS : (sm == 2'd1) ? OS * 3 / 2 : 2 * OS;
    for (int j = 0; j < ns; j++) begin
      f.w[p] = 1'b1;
      p++;
    end
    f.len = p;
    return f;
  endfunction

  // scoreboard push on every accepted request
  always @(posedge clk) begin
    if (!reset && bus.tx_start && bus.tx_ready) begin
      sb.push_back(model(bus.din, bus.data_bits,
                         bus.parity_mode, bus.stop_mode));
      acc_in_done = bus.tx_done_tick;
      n_acc++;
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 s_tick = ($urandom_range(0, 1) == 1);
    end
  end

  // monitor: record the line on every counted tick, check on done
  always @(negedge clk) begin
    frame_t f;
    bit     ok;
    if (reset) begin
      act_len = 0;
      act     = '0;
    end else begin
      n_cmp++;
      if (bus.tx_ready === bus.tx_busy
          || (bus.tx_ready && tx !== 1'b1)) begin
        n_err++;
        $display("FAIL idle_line: ready=%b busy=%b tx=%b, required ready!=busy and tx=1 when ready",
                 bus.tx_ready, bus.tx_busy, tx);
      end
      if (bus.tx_busy && s_tick) begin
        if (act_len < 256) act[act_len] = tx;
        act_len++;
      end
      if (bus.tx_done_tick) begin
        n_done++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done with %0d recorded ticks, required no done",
                   act_len);
        end else begin
          f  = sb.pop_front();
          ok = act_len == f.len;
          for (int i = 0; i < f.len; i++)
            if (act[i] !== f.w[i]) ok = 0;
          if (!ok) begin
            n_err++;
            $display("FAIL frame: got len=%0d wave=%h, required len=%0d wave=%h",
                     act_len, act, f.len, f.w);
          end
        end
        act_len = 0;
        act     = '0;
      end
    end
  end

  task automatic timeout(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL timeout_%s: got no event in %0d cycles, required event",
             what, LIM);
  endtask

  task automatic scramble();
    bus.din         = DBM'($urandom);
    bus.data_bits   = 2'($urandom);
    bus.parity_mode = 2'($urandom);
    bus.stop_mode   = 2'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (n_acc < target && t < LIM) begin
      step();
      t++;
    end
    if (t >= LIM) timeout("accept");
  endtask

  task automatic wait_done(input int target, input bit scr);
    int t = 0;
    while (n_done < target && t < LIM) begin
      if (scr) scramble();
      step();
      t++;
    end
    if (t >= LIM) timeout("done");
  endtask

  task automatic send(
    input logic [DBM-1:0] d,
    input logic [1:0] db,
    input logic [1:0] pm,
    input logic [1:0] sm
  );
    int t = 0;
    int a0;
    int d0;
    while (bus.tx_ready !== 1'b1 && t < LIM) begin
      step();
      t++;
    end
    if (t >= LIM) timeout("ready");
    a0 = n_acc;
    d0 = n_done;
    bus.din         = d;
    bus.data_bits   = db;
    bus.parity_mode = pm;
    bus.stop_mode   = sm;
    bus.tx_start    = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_start = 1'b0;
    wait_done(d0 + 1, 1'b1);
  endtask

  initial begin
    int a0;
    int d0;
    int t;
    reset           = 1'b1;
    bus.tx_start    = 1'b1;
    bus.din         = 8'hFF;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop_mode   = 2'b00;
    repeat (3) step();
    reset        = 1'b0;
    bus.tx_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || bus.tx_ready !== 1'b1
        || bus.tx_busy !== 1'b0 || bus.tx_done_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               tx, bus.tx_ready, bus.tx_busy, bus.tx_done_tick);
    end
    step();

    send(8'h55, 2'b11, 2'b00, 2'b00);
    send(8'hA3, 2'b10, 2'b01, 2'b00);
    send(8'h1F, 2'b00, 2'b10, 2'b10);
    send(8'h00, 2'b11, 2'b00, 2'b01);

    // held start: second frame must be taken in the done cycle
    a0 = n_acc;
    d0 = n_done;
    bus.din         = 8'h01;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b00;
    bus.stop_mode   = 2'b00;
    bus.tx_start    = 1'b1;
    wait_acc(a0 + 1);
    bus.din = 8'h80;
    wait_acc(a0 + 2);
    n_cmp++;
    if (!acc_in_done) begin
      n_err++;
      $display("FAIL b2b_gap: got accept outside done cycle, required accept with done=1");
    end
    bus.tx_start = 1'b0;
    wait_done(d0 + 2, 1'b0);

    // reset during data bit 3 aborts the frame silently
    a0 = n_acc;
    bus.din         = 8'hC6;
    bus.data_bits   = 2'b11;
    bus.parity_mode = 2'b01;
    bus.stop_mode   = 2'b00;
    bus.tx_start    = 1'b1;
    wait_acc(a0 + 1);
    bus.tx_start = 1'b0;
    t = 0;
    while (act_len < 70 && t < LIM) begin
      step();
      t++;
    end
    if (t >= LIM) timeout("bit3");
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got tx=%b ready=%b busy=%b, required 1 1 0",
               tx, bus.tx_ready, bus.tx_busy);
    end
    d0 = n_done;
    repeat (500) step();
    n_cmp++;
    if (n_done != d0) begin
      n_err++;
      $display("FAIL abort_done: got %0d done pulses, required 0",
               n_done - d0);
    end

    for (int k = 0; k < 25; k++) begin
      send(DBM'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 4)) step();
    end

    repeat (20) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d frames never completed, required 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
